// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side beat handshake plus the shared FIFO write port and grant status of fifo_wr_arbiter.
// master = requesters/FIFO environment, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BIT  = 2,
    parameter int DATA_BIT  = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*DATA_BIT-1:0]   req_data;
    logic [NUM_PORTS-1:0]            req_last;
    logic [NUM_PORTS-1:0]            req_ready;
    logic                            fifo_wr_en;
    logic [DATA_BIT+PORT_BIT:0]      fifo_wr_data;
    logic                            fifo_full;
    logic                            grant_valid;
    logic [PORT_BIT-1:0]             grant_port;
    logic                            pkt_done;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_port, pkt_done
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_port, pkt_done
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port; one idle arbitration cycle per packet,
// then 1 beat/cycle. fifo_full stalls the granted port in place with the grant held indefinitely.
module fifo_wr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BIT  = 2,
    parameter int DATA_BIT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [PORT_BIT-1:0]   grant_port, grant_port_nxt;
    logic                  grant_valid, grant_valid_nxt;
    logic [PORT_BIT-1:0]   rr_ptr, rr_ptr_nxt;
    logic                  pkt_done, pkt_done_nxt;

    logic [PORT_BIT-1:0]   scan_start;
    logic [NUM_PORTS-1:0]  req_rot;
    logic                  sel_found;
    logic [PORT_BIT:0]     sel_sum;
    logic [PORT_BIT-1:0]   sel_port;

    logic                  g_valid;
    logic                  g_last;
    logic [DATA_BIT-1:0]   g_data;
    logic [NUM_PORTS-1:0]  ready;
    logic                  wr_en;

    // Rotate requests so bit 0 is the port just after rr_ptr; the lowest set bit wins.
    always_comb begin
        scan_start = (rr_ptr == PORT_BIT'(NUM_PORTS - 1)) ? '0 : rr_ptr + 1'b1;
        req_rot    = NUM_PORTS'({bus.req_valid, bus.req_valid} >> scan_start);
        sel_found  = 1'b0;
        sel_sum    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_found = 1'b1;
                sel_sum   = {1'b0, scan_start} + (PORT_BIT+1)'(k);
            end
        end
        if (sel_sum >= (PORT_BIT+1)'(NUM_PORTS))
            sel_sum = sel_sum - (PORT_BIT+1)'(NUM_PORTS);
        sel_port = sel_sum[PORT_BIT-1:0];
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_port == PORT_BIT'(p)) begin
                g_valid = bus.req_valid[p];
                g_last  = bus.req_last[p];
                g_data  = bus.req_data[p*DATA_BIT +: DATA_BIT];
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_port_nxt  = grant_port;
        grant_valid_nxt = grant_valid;
        rr_ptr_nxt      = rr_ptr;
        pkt_done_nxt    = 1'b0;
        ready           = '0;
        wr_en           = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt       = BUSY;
                    grant_port_nxt  = sel_port;
                    grant_valid_nxt = 1'b1;
                end
            end
            BUSY: begin
                for (int p = 0; p < NUM_PORTS; p++)
                    ready[p] = (grant_port == PORT_BIT'(p)) && !bus.fifo_full;
                wr_en = g_valid && !bus.fifo_full;
                if (wr_en && g_last) begin
                    state_nxt       = IDLE;
                    grant_valid_nxt = 1'b0;
                    rr_ptr_nxt      = grant_port;
                    pkt_done_nxt    = 1'b1;
                end
            end
        endcase
        // Nothing is accepted while reset is asserted, even mid-packet.
        if (rst) begin
            ready = '0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_port  <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= PORT_BIT'(NUM_PORTS - 1);
            pkt_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_port  <= grant_port_nxt;
            grant_valid <= grant_valid_nxt;
            rr_ptr      <= rr_ptr_nxt;
            pkt_done    <= pkt_done_nxt;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = {g_last, grant_port, g_data};
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_port   = grant_port;
    assign bus.pkt_done     = pkt_done;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the switch's shared dual-clock buffer FIFO among NUM_PORTS ingress requesters, all in the write-clock domain.
- Round-robin arbitration at packet granularity: a granted port owns the FIFO write port until its last beat is written.
- Each FIFO word carries the last flag, the source port ID and the data, so the read side can demultiplex packets.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- PORT_BIT, 2, width of a port index; equals ceil(log2(NUM_PORTS)).
- DATA_BIT, 16, payload width per beat.

Ports:
- clk  input  1  write-side clock; the same clock as the FIFO write clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_PORTS  per-port beat valid.
- req_data  input  NUM_PORTS*DATA_BIT  per-port beat data; port i occupies bits [i*DATA_BIT +: DATA_BIT].
- req_last  input  NUM_PORTS  per-port flag marking the last beat of a packet.
- req_ready  output  NUM_PORTS  per-port beat accept.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_BIT+PORT_BIT+1  FIFO word = {last, port_id, data}.
- fifo_full  input  1  FIFO full flag, combinational from the FIFO.
- grant_valid  output  1  a packet grant is active.
- grant_port  output  PORT_BIT  index of the granted port.
- pkt_done  output  1  one-cycle pulse when a last beat is written.

Behaviour:
- Reset values: state=IDLE, grant_valid=0, grant_port=0, rr_ptr=NUM_PORTS-1 (so port 0 has first priority), pkt_done=0. Combinational outputs under reset: req_ready=0, fifo_wr_en=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any req_valid is high, select the first valid port scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register grant_port=selected and grant_valid=1, then go to BUSY.
  - No beat is accepted in IDLE, so there is a fixed 1-cycle arbitration bubble per packet.
- BUSY:
  - req_ready[g] = !fifo_full for g=grant_port; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & req_ready[g].
  - fifo_wr_data = {req_last[g], g, req_data[g]}, combinational mux.
  - On a write with req_last[g]=1: next cycle state=IDLE, grant_valid=0, rr_ptr=g, pkt_done=1 for exactly one cycle.
  - A packet may be a single beat.
- Backpressure: while fifo_full=1, req_ready=0 and fifo_wr_en=0. The grant is held with no time limit. Beats are never dropped or duplicated.
- Valid gaps: req_valid[g]=0 mid-packet keeps the grant held. Other ports wait; there is no preemption.
- The grant decision ignores req_last; requesters must present a well-formed packet.
- The arbiter never writes when fifo_full=1. The FIFO's own full guard is redundant but harmless.
- Fairness: after port g completes a packet, port g has the lowest priority in the next arbitration. With all ports continuously valid, grants rotate 0,1,2,3,0,...
- Wrap-around: the rr scan wraps from NUM_PORTS-1 to 0. For NUM_PORTS not a power of two, indices >= NUM_PORTS are never selected.
- Reset mid-packet: on the cycle after rst=1, state returns to IDLE and any partial packet is abandoned. The FIFO-side cleanup belongs to the system reset.
- Latency: first beat of a granted packet is written at the earliest 2 cycles after req_valid rises in IDLE (arbitration cycle, then write cycle). Throughput in BUSY is 1 beat per cycle.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, fifo_wr_en=0, grant_valid=0, grant_port=0 throughout.
- Single port: port 2 sends a 3-beat packet with data 0xA1,0xA2,0xA3 -> grant_port=2 one cycle after valid; fifo_wr_data=
  - {0,2,0x00A1}
  - {0,2,0x00A2}
  - {1,2,0x00A3}
  - on consecutive cycles, then pkt_done=1 for one cycle and grant_valid=0.
- Round-robin: all 4 ports continuously send 2-beat packets -> grant order 0,1,2,3,0,1. Each packet shows exactly 2 writes plus 1 bubble; no port is granted twice in a row.
- Backpressure: force fifo_full=1 for cycles 5..9 during port 1's 4-beat packet -> req_ready[1]=0 and fifo_wr_en=0 during those cycles. All 4 beats are written in order afterwards and no other port is granted meanwhile.
- Valid gap plus single-beat packet: port 3 drops req_valid mid-packet for 2 cycles while port 0 is valid -> grant stays 3 until port 3's last beat. Then port 0 sends a 1-beat packet with last=1 -> one write {1,0,data} and a pkt_done pulse.
- Reset mid-packet: assert rst for 1 cycle after beat 2 of a 5-beat packet from port 1 -> the next cycle is IDLE with rr_ptr=3. A subsequent request from ports 0 and 1 is granted to port 0 first.
